// File: rtl/mul_share_arbiter_if.sv
// Requester and result bus of the shared multiplier arbiter.
//   req_valid/req_a/req_b : packed per-requester operands, slot i at [i*DIN_W +: DIN_W]
//   req_ready             : one-hot accept back to the requesters
//   res_valid/res_data/res_id/res_ready : tagged product stream with backpressure
// modport slave is the arbiter side, modport master is the requester/consumer side.
interface mul_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DIN_W   = 10,
  parameter int unsigned DOUT_W  = 20
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DIN_W-1:0] req_a;
  logic [NUM_REQ*DIN_W-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic [DOUT_W-1:0]        res_data;
  logic [ID_W-1:0]          res_id;
  logic                     res_ready;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined unsigned multiplier among NUM_REQ requesters.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   bus (slave)        : requester operands/accept and tagged result stream
//   mul_ce             : multiplier clock enable (low only while the result is stalled)
//   mul_din0, mul_din1 : operands of the granted requester, zero on a bubble
//   mul_dout           : multiplier product, forwarded unmodified as res_data
//   busy               : at least one product in flight or waiting at the output
module mul_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DIN_W   = 10,
  parameter int unsigned DOUT_W  = 20,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  mul_share_arbiter_if.slave bus,
  output logic               mul_ce,
  output logic [DIN_W-1:0]   mul_din0,
  output logic [DIN_W-1:0]   mul_din1,
  input  logic [DOUT_W-1:0]  mul_dout,
  output logic               busy
);

  logic [ID_W-1:0]    rr_ptr;
  logic [MUL_LAT-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [MUL_LAT];

  logic               stall;
  logic               grant_found;
  logic               transfer;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic [DIN_W-1:0]   slot_a [NUM_REQ];
  logic [DIN_W-1:0]   slot_b [NUM_REQ];

  // Unpack the operand buses into per-requester slots.
  always_comb begin : unpack_slots
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot_a[i] = bus.req_a[i*DIN_W +: DIN_W];
      slot_b[i] = bus.req_b[i*DIN_W +: DIN_W];
    end
  end

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin : arbitrate
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // A held result freezes the multiplier and the tag pipeline together.
  assign stall    = bus.res_valid & ~bus.res_ready;
  assign mul_ce   = ~stall;
  // Reset gating keeps req_ready low while reset is held, even with requests pending.
  assign transfer = grant_found & ~stall & ~reset;

  // Accept strobe and operand steering for the granted requester.
  always_comb begin : drive_grant
    bus.req_ready = '0;
    mul_din0      = '0;
    mul_din1      = '0;
    if (transfer) begin
      bus.req_ready[grant_id] = 1'b1;
      mul_din0                = slot_a[grant_id];
      mul_din1                = slot_b[grant_id];
    end
  end

  // Tag pipeline mirrors the multiplier latency; the pointer moves past each grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      rr_ptr    <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      if (mul_ce) begin
        tag_valid[0] <= transfer;
        tag_id[0]    <= grant_id;
        for (int unsigned k = 1; k < MUL_LAT; k++) begin
          tag_valid[k] <= tag_valid[k-1];
          tag_id[k]    <= tag_id[k-1];
        end
      end
      if (transfer) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  // The multiplier has no reset; its stale contents are masked by the cleared valids.
  assign bus.res_valid = tag_valid[MUL_LAT-1];
  assign bus.res_id    = tag_id[MUL_LAT-1];
  assign bus.res_data  = mul_dout;
  assign busy          = |tag_valid;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-based latency model of the shared multiplier.
module tb_mul_share_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned DIN_W   = 10;
  localparam int unsigned DOUT_W  = 20;
  localparam int unsigned MUL_LAT = 3;

  typedef struct {
    bit          v;
    int unsigned id;
    int unsigned prod;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              mul_ce;
  logic [DIN_W-1:0]  mul_din0;
  logic [DIN_W-1:0]  mul_din1;
  logic [DOUT_W-1:0] mul_dout;
  logic              busy;

  mul_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus ();

  mul_share_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mul_ce   (mul_ce),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pipelined multiplier with ce and no reset.
  logic [DOUT_W-1:0] mpipe [MUL_LAT];
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= DOUT_W'(mul_din0) * DOUT_W'(mul_din1);
      for (int k = 1; k < int'(MUL_LAT); k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mul_dout = mpipe[MUL_LAT-1];

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned cyc;
  bit          pend     [NUM_REQ];
  int unsigned op_a     [NUM_REQ];
  int unsigned op_b     [NUM_REQ];
  int unsigned load_cyc [NUM_REQ];
  int unsigned ptr;
  ent_t        pipe [$];
  bit          rr_drive;
  int unsigned last_data;
  int unsigned last_id;
  int unsigned max_wait0;
  int unsigned grants0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load(input int unsigned i, input int unsigned a, input int unsigned b);
    if (!pend[i]) begin
      pend[i]     = 1'b1;
      op_a[i]     = a;
      op_b[i]     = b;
      load_cyc[i] = cyc;
    end
  endtask

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0; e.id = 0; e.prod = 0;
    pipe.delete();
    for (int k = 0; k < int'(MUL_LAT); k++) pipe.push_back(e);
    ptr = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) pend[i] = 1'b0;
  endtask

  function automatic bit model_busy();
    bit any_v = 1'b0;
    foreach (pipe[k]) any_v |= pipe[k].v;
    return any_v;
  endfunction

  function automatic bit pending_any();
    bit p = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) p |= pend[i];
    return p;
  endfunction

  // One clock: drive at negedge, check at negedge+1, advance the model for the next edge.
  task automatic tick();
    logic [NUM_REQ-1:0] exp_rdy;
    bit          stall, found, any_v;
    int unsigned g, exp_a, exp_b, w;
    ent_t        out, e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_valid[i]                  = pend[i];
      bus.req_a[i*int'(DIN_W) +: DIN_W] = DIN_W'(op_a[i]);
      bus.req_b[i*int'(DIN_W) +: DIN_W] = DIN_W'(op_b[i]);
    end
    bus.res_ready = rr_drive;
    #1;
    out     = pipe[MUL_LAT-1];
    any_v   = model_busy();
    stall   = out.v && !rr_drive;
    found   = 1'b0;
    g       = 0;
    exp_rdy = '0;
    exp_a   = 0;
    exp_b   = 0;
    if (!reset && !stall) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        int unsigned i;
        i = (ptr + k) % NUM_REQ;
        if (!found && pend[i]) begin
          found = 1'b1;
          g     = i;
        end
      end
    end
    if (found) begin
      exp_rdy[g] = 1'b1;
      exp_a      = op_a[g];
      exp_b      = op_b[g];
    end
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("mul_ce",    32'(mul_ce),        32'(!stall));
    check("mul_din0",  32'(mul_din0),      exp_a);
    check("mul_din1",  32'(mul_din1),      exp_b);
    check("res_valid", 32'(bus.res_valid), 32'(out.v));
    check("busy",      32'(busy),          32'(any_v));
    if (out.v) begin
      check("res_data", 32'(bus.res_data), out.prod);
      check("res_id",   32'(bus.res_id),   out.id);
    end
    if (!reset) begin
      if (bus.res_valid && rr_drive) begin
        last_data = 32'(bus.res_data);
        last_id   = 32'(bus.res_id);
      end
      if (!stall) begin
        e.v    = found;
        e.id   = g;
        e.prod = exp_a * exp_b;
        pipe.push_front(e);
        void'(pipe.pop_back());
      end
      if (found) ptr = (g + 1) % NUM_REQ;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (bus.req_ready[i] && pend[i]) begin
          pend[i] = 1'b0;
          if (i == 0) begin
            w = cyc - load_cyc[0];
            if (w > max_wait0) max_wait0 = w;
            grants0++;
          end
        end
      end
    end
  endtask

  task automatic drain();
    int unsigned guard = 0;
    rr_drive = 1'b1;
    while ((pending_any() || model_busy()) && guard < 50) begin
      tick();
      guard++;
    end
    check("drain_done", 32'(guard < 50), 32'd1);
  endtask

  task automatic load_stream();
    for (int i = 0; i < int'(NUM_REQ); i++) load(i, i + 1, 10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    last_data = 0; last_id = 0; max_wait0 = 0; grants0 = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      op_a[i] = 0; op_b[i] = 0; load_cyc[i] = 0;
    end
    reset         = 1'b1;
    rr_drive      = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Single request, 3x5.
    load(0, 3, 5);
    repeat (6) tick();
    check("single_data", last_data, 32'd15);
    check("single_id",   last_id,   32'd0);

    // All four requesters streaming.
    repeat (12) begin load_stream(); tick(); end

    // Backpressure for 5 cycles with a result held at the output.
    begin
      int unsigned guard = 0;
      while (!pipe[MUL_LAT-1].v && guard < 20) begin load_stream(); tick(); guard++; end
    end
    rr_drive = 1'b0;
    repeat (5) begin load_stream(); tick(); end
    rr_drive = 1'b1;
    repeat (8) begin load_stream(); tick(); end
    drain();

    // Full-scale operands.
    load(1, 1023, 1023);
    drain();
    check("full_scale", last_data, 32'h000FF801);
    check("full_id",    last_id,   32'd1);

    // Fairness: requester 2 always valid, requester 0 pulsing.
    max_wait0 = 0;
    grants0   = 0;
    for (int c = 0; c < 40; c++) begin
      load(2, c, 7);
      if (c % 4 == 0) load(0, 100 + c, 3);
      tick();
    end
    drain();
    check("fair_wait",   32'(max_wait0 <= 2), 32'd1);
    check("fair_grants", grants0,             32'd10);

    // Random traffic with random backpressure.
    repeat (300) begin
      for (int i = 0; i < int'(NUM_REQ); i++)
        if ($urandom_range(1, 0) == 1) load(i, $urandom_range(1023, 0), $urandom_range(1023, 0));
      rr_drive = ($urandom_range(3, 0) != 0);
      tick();
    end
    drain();

    // Reset with three products in flight.
    repeat (4) begin load_stream(); tick(); end
    #2 reset = 1'b1;
    #1;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    last_data = 0;
    last_id   = 3;
    repeat (3) tick();
    load(0, 7, 9);
    repeat (5) tick();
    check("post_rst_data", last_data, 32'd63);
    check("post_rst_id",   last_id,   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Time-multiplexes one pipelined unsigned multiplier among NUM_REQ requesters in the packed-convolution datapath.
- The multiplier is the 10x10->20 DSP48 instance with a ce input and no reset.
- Each cycle the block round-robin grants at most one requester and drives the multiplier operands and ce.
- It tracks requester IDs through the multiplier latency and returns each product tagged with its requester ID over a valid/ready result port, with backpressure.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- ID_W, 2: requester ID width; equals clog2(NUM_REQ).
- DIN_W, 10: operand width.
- DOUT_W, 20: product width; equals 2*DIN_W.
- MUL_LAT, 3: number of ce-enabled register edges from multiplier din sample to dout; must match the instantiated multiplier.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_a  in  NUM_REQ*DIN_W  packed operand A; slot i = bits [i*DIN_W +: DIN_W]
- req_b  in  NUM_REQ*DIN_W  packed operand B
- req_ready  out  NUM_REQ  one-hot accept; combinational
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  DIN_W  multiplier operand A
- mul_din1  out  DIN_W  multiplier operand B
- mul_dout  in  DOUT_W  multiplier product
- res_valid  out  1  result valid
- res_data  out  DOUT_W  product; equals mul_dout
- res_id  out  ID_W  requester that issued the product
- res_ready  in  1  downstream accept
- busy  out  1  at least one product in flight or pending

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high; all block registers clear immediately on assertion.
- Reset values:
  - tag pipeline valid bits = 0, so res_valid = 0 and busy = 0.
  - rr_ptr = 0.
  - req_ready = 0, mul_ce = 1, mul_din0/1 = 0.
  - The multiplier holds no reset; its garbage contents are masked by the cleared tag valids.
- Stall: stall = res_valid & ~res_ready; mul_ce = ~stall. While stalled:
  - no grant, req_ready = 0.
  - tag pipeline and multiplier hold, so res_data/res_id stay stable until accepted.
- Arbitration (combinational, only when ~stall):
  - Grant g = first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g] = 1; mul_din0 = req_a slot g; mul_din1 = req_b slot g.
  - With no valid request, mul_din0/1 = 0 and a bubble is issued.
  - req_ready never depends on res_ready except through stall.
- Handshake: a requester transfer occurs when req_valid[i] & req_ready[i]. Requesters hold valid and data until accepted; at most one transfer per cycle.
- Pointer update: on a transfer to g, rr_ptr <= (g+1) mod NUM_REQ; otherwise rr_ptr holds.
- Tag pipeline: MUL_LAT entries of {valid, id}.
  - On mul_ce, stage 0 <= {transfer, g} and stage k <= stage k-1.
  - res_valid = last.valid; res_id = last.id.
- Latency: a product issued in cycle T appears as res_valid in cycle T+MUL_LAT when no stalls occur; each stall cycle adds one.
- Throughput: one product per cycle with res_ready held high.
- Simultaneous events:
  - A result handshake and a new grant may occur in the same cycle whenever res_ready = 1.
  - A pipeline bubble in the last stage never stalls.
- busy = OR of all tag valid bits.
- Arithmetic: unsigned; the block does no arithmetic on data, res_data = mul_dout unmodified. Full scale is 1023*1023 = 1046529 = 0xFF801.
- Reset mid-operation: in-flight products are discarded and never presented, the pointer returns to 0, and the first request after deassertion issues normally.

Test Plan:
- Single request: req_valid = 0001, a = 3, b = 5, res_ready = 1 -> req_ready = 0001 in the same cycle; res_valid exactly 3 cycles later with res_data = 15, res_id = 0; busy falls the following cycle.
- Round-robin: all four requesters continuously valid, a = i+1, b = 10 -> grants 0,1,2,3,0,...; results 10,20,30,40 with ids 0..3 on consecutive cycles.
- Backpressure: stream as in the round-robin test, drop res_ready for 5 cycles once res_valid = 1 -> the held result stays stable, req_ready = 0 and mul_ce = 0 for those cycles; after release there is no loss or duplication and the order is preserved.
- Full scale: a = b = 1023 -> res_data = 0xFF801.
- Fairness: requester 2 valid permanently, requester 0 pulsing -> requester 0 is granted within 2 cycles of each assertion and never starved.
- Reset mid-stream: assert reset asynchronously with 3 products in flight -> res_valid and busy drop immediately; after deassertion no stale result appears, and a new request a = 7, b = 9 returns 63 with id 0 after 3 cycles.
